// File: rtl/operand_issue_stage_pkg.sv
// Shared micro-instruction types for decode, issue and execute.
//
// Contents:
//   REG_N / REG_W / REG_AW  register file geometry
//   miop_e, bmd_e           micro-op and byte-mode encodings
//   miinst_t                decoded micro-instruction
//   de_reg_t                registered bundle handed to execute
//   nop()                   canonical bubble instruction
//   writes_rd / uses_rs / uses_rt / uses_rd
//                           operand truth table shared by decode and issue
package operand_issue_stage_pkg;

  localparam int unsigned REG_N  = 32;
  localparam int unsigned REG_W  = 64;
  localparam int unsigned REG_AW = $clog2(REG_N);

  typedef enum logic [3:0] {
    MIOP_NOP  = 4'd0,
    MIOP_ADD  = 4'd1,
    MIOP_SUB  = 4'd2,
    MIOP_AND  = 4'd3,
    MIOP_OR   = 4'd4,
    MIOP_ADDI = 4'd5,
    MIOP_L    = 4'd6,  // load: rd <= mem[rs + imm]
    MIOP_S    = 4'd7,  // store: mem[rs + imm] <= rd
    MIOP_BEQ  = 4'd8,
    MIOP_JAL  = 4'd9   // rd <= pc + 4, no register sources
  } miop_e;

  typedef enum logic [1:0] {
    BMD_B = 2'd0,
    BMD_H = 2'd1,
    BMD_W = 2'd2,
    BMD_D = 2'd3
  } bmd_e;

  typedef struct packed {
    miop_e             op;
    bmd_e              bmd;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [31:0]       imm;
    logic [31:0]       pc;
  } miinst_t;

  typedef struct packed {
    miinst_t          miinst;
    logic [REG_W-1:0] d;
    logic [REG_W-1:0] s;
    logic [REG_W-1:0] t;
  } de_reg_t;

  // All-zero encoding doubles as the bubble, so a reset register is already a nop.
  function automatic miinst_t nop();
    miinst_t m;
    m = '0;
    return m;
  endfunction

  function automatic logic writes_rd(input miop_e op);
    logic r;
    unique case (op)
      MIOP_ADD, MIOP_SUB, MIOP_AND, MIOP_OR,
      MIOP_ADDI, MIOP_L, MIOP_JAL:             r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs(input miop_e op);
    logic r;
    unique case (op)
      MIOP_ADD, MIOP_SUB, MIOP_AND, MIOP_OR,
      MIOP_ADDI, MIOP_L, MIOP_S, MIOP_BEQ:     r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rt(input miop_e op);
    logic r;
    unique case (op)
      MIOP_ADD, MIOP_SUB, MIOP_AND, MIOP_OR,
      MIOP_BEQ:                                r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

  // Only stores read rd (as the data to be written to memory).
  function automatic logic uses_rd(input miop_e op);
    logic r;
    unique case (op)
      MIOP_S:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/operand_bypass_select.sv
// Combinational operand fetch for one register index.
//
// Scans the bypass taps from youngest (index 0) to oldest and returns the
// first result destined for i_idx, falling back to the register file. Also
// flags when the matching producer is a load whose data is not yet valid.
//
// Ports:
//   i_idx         register index to read
//   i_gpr         architectural register file
//   i_fwd_miinst  in-flight instructions, youngest at index 0
//   i_fwd_d       their results
//   o_value       resolved operand value
//   o_not_ready   matching producer is a load still inside its latency window
module operand_bypass_select
  import operand_issue_stage_pkg::*;
#(
  parameter int unsigned FWD_N        = 4,
  parameter int unsigned LOAD_LATENCY = 1
) (
  input  logic    [REG_AW-1:0]           i_idx,
  input  logic    [REG_N-1:0][REG_W-1:0] i_gpr,
  input  miinst_t [FWD_N-1:0]            i_fwd_miinst,
  input  logic    [FWD_N-1:0][REG_W-1:0] i_fwd_d,
  output logic    [REG_W-1:0]            o_value,
  output logic                           o_not_ready
);

  logic w_hit;
  logic w_unused;

  // Only op and rd of each tap matter here.
  assign w_unused = ^i_fwd_miinst;

  always_comb begin
    o_value     = i_gpr[i_idx];
    o_not_ready = 1'b0;
    w_hit       = 1'b0;
    for (int unsigned k = 0; k < FWD_N; k++) begin
      if (!w_hit && writes_rd(i_fwd_miinst[k].op) && (i_fwd_miinst[k].rd == i_idx)) begin
        w_hit       = 1'b1;
        o_value     = i_fwd_d[k];
        // Load data only lands on the bypass at index LOAD_LATENCY+2.
        o_not_ready = (i_fwd_miinst[k].op == MIOP_L) && (k < LOAD_LATENCY + 2);
      end
    end
  end

endmodule

// File: rtl/operand_issue_stage.sv
// Operand issue stage: buffers decoded micro-instructions in a small FIFO,
// resolves source operands (register file plus bypass), interlocks on
// load-use hazards and drives the registered de_reg bundle into execute.
//
// Reset is synchronous, active-low (rstn). Build option ISSUE_STATS_EN adds
// saturating stall/issue counters.
//
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   i_in_valid      decoder offers i_in_miinst
//   i_in_miinst     decoded micro-instruction
//   o_in_ready      FIFO accepts this cycle (combinational)
//   i_gpr           architectural register file contents
//   i_fwd_miinst    in-flight instructions, youngest at index 0
//   i_fwd_d         their results
//   i_flush         taken branch from execute; discards all buffered work
//   o_stall_cnt     hazard-stall cycles, saturating (ISSUE_STATS_EN only)
//   o_issue_cnt     issued instructions, saturating (ISSUE_STATS_EN only)
//   o_de_reg        {miinst, d, s, t} to execute, registered
//   o_de_valid      o_de_reg holds a real instruction (0 = bubble)
module operand_issue_stage
  import operand_issue_stage_pkg::*;
#(
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned FWD_N        = 4,
  parameter int unsigned LOAD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_in_valid,
  input  miinst_t                        i_in_miinst,
  output logic                           o_in_ready,
  input  logic    [REG_N-1:0][REG_W-1:0] i_gpr,
  input  miinst_t [FWD_N-1:0]            i_fwd_miinst,
  input  logic    [FWD_N-1:0][REG_W-1:0] i_fwd_d,
  input  logic                           i_flush,
`ifdef ISSUE_STATS_EN
  output logic    [31:0]                 o_stall_cnt,
  output logic    [31:0]                 o_issue_cnt,
`endif
  output de_reg_t                        o_de_reg,
  output logic                           o_de_valid
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  // FIFO storage and state
  miinst_t          r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Output register
  de_reg_t r_de_reg;
  logic    r_de_valid;

  // Head operand resolution
  miinst_t          w_head;
  logic [REG_W-1:0] w_s;
  logic [REG_W-1:0] w_t;
  logic [REG_W-1:0] w_d;
  logic             w_nr_s;
  logic             w_nr_t;
  logic             w_nr_d;
  logic             w_stall;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  assign w_head  = r_mem[r_rptr];
  assign w_empty = (r_count == '0);

  operand_bypass_select #(
    .FWD_N        (FWD_N),
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_sel_s (
    .i_idx        (w_head.rs),
    .i_gpr        (i_gpr),
    .i_fwd_miinst (i_fwd_miinst),
    .i_fwd_d      (i_fwd_d),
    .o_value      (w_s),
    .o_not_ready  (w_nr_s)
  );

  operand_bypass_select #(
    .FWD_N        (FWD_N),
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_sel_t (
    .i_idx        (w_head.rt),
    .i_gpr        (i_gpr),
    .i_fwd_miinst (i_fwd_miinst),
    .i_fwd_d      (i_fwd_d),
    .o_value      (w_t),
    .o_not_ready  (w_nr_t)
  );

  operand_bypass_select #(
    .FWD_N        (FWD_N),
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_sel_d (
    .i_idx        (w_head.rd),
    .i_gpr        (i_gpr),
    .i_fwd_miinst (i_fwd_miinst),
    .i_fwd_d      (i_fwd_d),
    .o_value      (w_d),
    .o_not_ready  (w_nr_d)
  );

  // A not-ready operand only matters if the head op actually reads it.
  assign w_stall = (uses_rs(w_head.op) & w_nr_s) |
                   (uses_rt(w_head.op) & w_nr_t) |
                   (uses_rd(w_head.op) & w_nr_d);

  assign w_pop      = !i_flush && !w_empty && !w_stall;
  assign o_in_ready = (r_count < FULL_CNT) || w_pop;
  // A push coinciding with a flush belongs to the discarded path.
  assign w_push     = i_in_valid && o_in_ready && !i_flush;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_in_miinst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr            <= '0;
      r_rptr            <= '0;
      r_count           <= '0;
      r_de_reg.miinst   <= nop();
      r_de_reg.d        <= '0;
      r_de_reg.s        <= '0;
      r_de_reg.t        <= '0;
      r_de_valid        <= 1'b0;
    end else if (i_flush) begin
      r_wptr            <= '0;
      r_rptr            <= '0;
      r_count           <= '0;
      r_de_reg.miinst   <= nop();
      r_de_reg.d        <= '0;
      r_de_reg.s        <= '0;
      r_de_reg.t        <= '0;
      r_de_valid        <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      if (w_pop) begin
        r_de_reg.miinst <= w_head;
        r_de_reg.d      <= w_d;
        r_de_reg.s      <= w_s;
        r_de_reg.t      <= w_t;
        r_de_valid      <= 1'b1;
      end else begin
        r_de_reg.miinst <= nop();
        r_de_reg.d      <= '0;
        r_de_reg.s      <= '0;
        r_de_reg.t      <= '0;
        r_de_valid      <= 1'b0;
      end
    end
  end

  assign o_de_reg   = r_de_reg;
  assign o_de_valid = r_de_valid;

`ifdef ISSUE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_issue_cnt;
  logic        w_stall_cycle;

  // Hazard stall only: an empty FIFO is idle, not stalled.
  assign w_stall_cycle = !i_flush && !w_empty && w_stall;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_issue_cnt <= '0;
    end else begin
      if (w_stall_cycle && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_pop && (r_issue_cnt != '1)) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_issue_cnt = r_issue_cnt;
`endif

endmodule
